// File: rtl/bus_snoop_responder.sv
// Bus snoop responder: accepts one snooped bus operation at a time, looks the
// address up in the tag store, applies the MESI snoop transition, pushes a
// dirty line out through the write-back port when required and reports
// NOHIT/HIT/HITM. All outputs come from registers.
// Optional build macro: SNOOP_STATS_EN adds saturating snoop/HITM counters.
module bus_snoop_responder #(
  parameter int ADD_SIZE = 32,
  parameter int WAY_BITS = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                snoop_valid,
  input  logic [1:0]          snoop_op,
  input  logic [ADD_SIZE-1:0] snoop_addr,
  output logic                snoop_ready,
  output logic                lk_req,
  output logic [ADD_SIZE-1:0] lk_addr,
  input  logic                lk_ack,
  input  logic                lk_hit,
  input  logic [WAY_BITS-1:0] lk_way,
  input  logic [1:0]          lk_mesi,
  output logic                upd_valid,
  output logic [ADD_SIZE-1:0] upd_addr,
  output logic [WAY_BITS-1:0] upd_way,
  output logic [1:0]          upd_mesi,
  output logic                wb_req,
  output logic [ADD_SIZE-1:0] wb_addr,
  input  logic                wb_ack,
  output logic                rsp_valid,
  output logic [1:0]          rsp_result,
  output logic                proto_err,
  output logic [15:0]         stat_snoops,
  output logic [15:0]         stat_hitm
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    DECIDE    = 3'd2,
    WRITEBACK = 3'd3,
    RESPOND   = 3'd4
  } state_t;

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_MODIFY = 2'b10;
  localparam logic [1:0] OP_INVAL  = 2'b11;

  localparam logic [1:0] MESI_I = 2'b00;
  localparam logic [1:0] MESI_S = 2'b01;
  localparam logic [1:0] MESI_E = 2'b10;
  localparam logic [1:0] MESI_M = 2'b11;

  localparam logic [1:0] RES_NOHIT = 2'b00;
  localparam logic [1:0] RES_HIT   = 2'b01;
  localparam logic [1:0] RES_HITM  = 2'b10;

  state_t                state_r, next_state_s;
  logic [1:0]            op_r;
  logic [ADD_SIZE-1:0]   addr_r;
  logic                  hit_r;
  logic [WAY_BITS-1:0]   way_r;
  logic [1:0]            mesi_r;

  logic                  accept_s;
  logic                  line_valid_s;
  logic [1:0]            new_mesi_s;
  logic [1:0]            result_s;
  logic                  change_s;
  logic                  wb_need_s;
  logic                  err_s;

  logic                  snoop_ready_r;
  logic                  lk_req_r;
  logic                  wb_req_r;
  logic                  rsp_valid_r;
  logic [1:0]            rsp_result_r;
  logic                  upd_valid_r;
  logic [ADD_SIZE-1:0]   upd_addr_r;
  logic [WAY_BITS-1:0]   upd_way_r;
  logic [1:0]            upd_mesi_r;
  logic                  proto_err_r;

  // Snoop inputs are only looked at while idle, so anything driven while busy is ignored.
  assign accept_s     = snoop_valid && (state_r == IDLE);
  assign line_valid_s = hit_r && (mesi_r != MESI_I);

  // MESI snoop decision from the captured op and lookup result; stable from DECIDE onward.
  always_comb begin
    new_mesi_s = mesi_r;
    result_s   = RES_NOHIT;
    change_s   = 1'b0;
    wb_need_s  = 1'b0;
    err_s      = 1'b0;
    if (line_valid_s) begin
      case (op_r)
        OP_READ: begin
          case (mesi_r)
            MESI_M: begin new_mesi_s = MESI_S; change_s = 1'b1; wb_need_s = 1'b1; result_s = RES_HITM; end
            MESI_E: begin new_mesi_s = MESI_S; change_s = 1'b1; result_s = RES_HIT; end
            MESI_S: begin result_s = RES_HIT; end
            default: begin result_s = RES_NOHIT; end
          endcase
        end
        OP_MODIFY: begin
          case (mesi_r)
            MESI_M: begin new_mesi_s = MESI_I; change_s = 1'b1; wb_need_s = 1'b1; result_s = RES_HITM; end
            MESI_E, MESI_S: begin new_mesi_s = MESI_I; change_s = 1'b1; result_s = RES_HIT; end
            default: begin result_s = RES_NOHIT; end
          endcase
        end
        OP_INVAL: begin
          case (mesi_r)
            MESI_S: begin new_mesi_s = MESI_I; change_s = 1'b1; result_s = RES_HIT; end
            // An invalidate hitting an exclusive/modified copy means another owner exists: flag, keep line.
            MESI_E, MESI_M: begin result_s = RES_HIT; err_s = 1'b1; end
            default: begin result_s = RES_NOHIT; end
          endcase
        end
        OP_WRITE: begin
          // Another master writing a line we hold valid is a coherence violation.
          result_s = RES_NOHIT;
          err_s    = 1'b1;
        end
        default: begin result_s = RES_NOHIT; end
      endcase
    end else begin
      result_s = RES_NOHIT;
    end
  end

  // Next-state logic of the snoop sequencer.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:      if (accept_s) next_state_s = LOOKUP;    else next_state_s = IDLE;
      LOOKUP:    if (lk_ack)   next_state_s = DECIDE;    else next_state_s = LOOKUP;
      DECIDE:    if (wb_need_s) next_state_s = WRITEBACK; else next_state_s = RESPOND;
      WRITEBACK: if (wb_ack)   next_state_s = RESPOND;   else next_state_s = WRITEBACK;
      RESPOND:   next_state_s = IDLE;
      default:   next_state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= next_state_s;
  end

  // Capture the accepted snoop and the tag lookup result.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r   <= 2'b00;
      addr_r <= '0;
      hit_r  <= 1'b0;
      way_r  <= '0;
      mesi_r <= 2'b00;
    end else begin
      if (accept_s) begin
        op_r   <= snoop_op;
        addr_r <= snoop_addr;
      end
      if ((state_r == LOOKUP) && lk_ack) begin
        hit_r  <= lk_hit;
        way_r  <= lk_way;
        mesi_r <= lk_mesi;
      end
    end
  end

  // Output registers loaded from the next state so each strobe lines up with its state.
  always_ff @(posedge clk) begin
    if (reset) begin
      snoop_ready_r <= 1'b1;
      lk_req_r      <= 1'b0;
      wb_req_r      <= 1'b0;
      rsp_valid_r   <= 1'b0;
      rsp_result_r  <= RES_NOHIT;
      upd_valid_r   <= 1'b0;
      upd_addr_r    <= '0;
      upd_way_r     <= '0;
      upd_mesi_r    <= MESI_I;
      proto_err_r   <= 1'b0;
    end else begin
      snoop_ready_r <= (next_state_s == IDLE);
      lk_req_r      <= (next_state_s == LOOKUP);
      wb_req_r      <= (next_state_s == WRITEBACK);
      rsp_valid_r   <= (next_state_s == RESPOND);
      if (next_state_s == RESPOND) begin
        rsp_result_r <= result_s;
        upd_valid_r  <= change_s;
        proto_err_r  <= err_s;
        upd_addr_r   <= addr_r;
        upd_way_r    <= way_r;
        upd_mesi_r   <= new_mesi_s;
      end else begin
        rsp_result_r <= RES_NOHIT;
        upd_valid_r  <= 1'b0;
        proto_err_r  <= 1'b0;
      end
    end
  end

  assign snoop_ready = snoop_ready_r;
  assign lk_req      = lk_req_r;
  assign lk_addr     = addr_r;
  assign wb_req      = wb_req_r;
  assign wb_addr     = addr_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_result  = rsp_result_r;
  assign upd_valid   = upd_valid_r;
  assign upd_addr    = upd_addr_r;
  assign upd_way     = upd_way_r;
  assign upd_mesi    = upd_mesi_r;
  assign proto_err   = proto_err_r;

`ifdef SNOOP_STATS_EN
  logic [15:0] stat_snoops_r;
  logic [15:0] stat_hitm_r;

  // Saturating counters of accepted snoops and of HITM responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_snoops_r <= 16'd0;
      stat_hitm_r   <= 16'd0;
    end else begin
      if (accept_s && (stat_snoops_r != 16'hFFFF)) stat_snoops_r <= stat_snoops_r + 16'd1;
      if ((next_state_s == RESPOND) && (result_s == RES_HITM) && (stat_hitm_r != 16'hFFFF))
        stat_hitm_r <= stat_hitm_r + 16'd1;
    end
  end

  assign stat_snoops = stat_snoops_r;
  assign stat_hitm   = stat_hitm_r;
`else
  assign stat_snoops = 16'd0;
  assign stat_hitm   = 16'd0;
`endif

endmodule

// File: tb/tb_bus_snoop_responder.sv
// Directed bench for bus_snoop_responder: a table of snoop vectors with
// hand-computed MESI outcomes, plus hand-written reset and statistics sequences.
module tb_bus_snoop_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        snoop_valid;
  logic [1:0]  snoop_op;
  logic [31:0] snoop_addr;
  logic        snoop_ready;
  logic        lk_req;
  logic [31:0] lk_addr;
  logic        lk_ack;
  logic        lk_hit;
  logic [2:0]  lk_way;
  logic [1:0]  lk_mesi;
  logic        upd_valid;
  logic [31:0] upd_addr;
  logic [2:0]  upd_way;
  logic [1:0]  upd_mesi;
  logic        wb_req;
  logic [31:0] wb_addr;
  logic        wb_ack;
  logic        rsp_valid;
  logic [1:0]  rsp_result;
  logic        proto_err;
  logic [15:0] stat_snoops;
  logic [15:0] stat_hitm;

  always #5 clk = ~clk;

  bus_snoop_responder #(.ADD_SIZE(32), .WAY_BITS(3)) dut (
    .clk(clk), .reset(reset),
    .snoop_valid(snoop_valid), .snoop_op(snoop_op), .snoop_addr(snoop_addr), .snoop_ready(snoop_ready),
    .lk_req(lk_req), .lk_addr(lk_addr), .lk_ack(lk_ack), .lk_hit(lk_hit), .lk_way(lk_way), .lk_mesi(lk_mesi),
    .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_way(upd_way), .upd_mesi(upd_mesi),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_ack(wb_ack),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .proto_err(proto_err),
    .stat_snoops(stat_snoops), .stat_hitm(stat_hitm)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic        hit;
    logic [2:0]  way;
    logic [1:0]  mesi;
    int          lk_dly;
    int          wb_dly;
    logic        noise;
    logic [1:0]  exp_res;
    logic        exp_upd;
    logic [1:0]  exp_mesi;
    logic        exp_wb;
    logic        exp_err;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  int n_cmp = 0;
  int n_bad = 0;
  int exp_snoops = 0;
  int exp_hitm = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_stats(input string tag);
`ifdef SNOOP_STATS_EN
    check({tag, " stat_snoops"}, 32'(stat_snoops), 32'(exp_snoops));
    check({tag, " stat_hitm"},   32'(stat_hitm),   32'(exp_hitm));
`else
    check({tag, " stat_snoops"}, 32'(stat_snoops), 32'd0);
    check({tag, " stat_hitm"},   32'(stat_hitm),   32'd0);
`endif
  endtask

  // Issues one snoop (called at a negedge while idle), plays the tag store and
  // write-back target with the requested ack delays, and checks the outcome.
  task automatic run_snoop(input vec_t v, input string tag);
    int cyc, lat, exp_lat, lk_cycles, wb_cycles, upd_cycles, err_cycles;
    logic got, addr_ok;
    logic [1:0] res, umesi;
    logic [2:0] uway;
    logic [31:0] uaddr;
    cyc = 0; lat = 0; lk_cycles = 0; wb_cycles = 0; upd_cycles = 0; err_cycles = 0;
    got = 1'b0; addr_ok = 1'b1; res = 2'b00; umesi = 2'b00; uway = 3'd0; uaddr = 32'd0;
    check({tag, " ready"}, 32'(snoop_ready), 32'd1);
    snoop_valid = 1'b1; snoop_op = v.op; snoop_addr = v.addr;
    lk_hit = v.hit; lk_way = v.way; lk_mesi = v.mesi; lk_ack = 1'b0; wb_ack = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (v.noise) begin
        snoop_valid = 1'b1;
        snoop_op    = 2'($urandom_range(3, 0));
        snoop_addr  = 32'($urandom);
      end else begin
        snoop_valid = 1'b0;
      end
      if (lk_req) begin lk_cycles++; if (lk_addr !== v.addr) addr_ok = 1'b0; end
      if (wb_req) begin wb_cycles++; if (wb_addr !== v.addr) addr_ok = 1'b0; end
      if (upd_valid) begin upd_cycles++; uway = upd_way; umesi = upd_mesi; uaddr = upd_addr; end
      if (proto_err) err_cycles++;
      lk_ack = lk_req && (lk_cycles > v.lk_dly);
      wb_ack = wb_req && (wb_cycles > v.wb_dly);
      if (rsp_valid) begin got = 1'b1; lat = cyc; res = rsp_result; end
    end
    snoop_valid = 1'b0; lk_ack = 1'b0; wb_ack = 1'b0;
    @(negedge clk);
    if (upd_valid) upd_cycles++;
    if (proto_err) err_cycles++;
    exp_lat = 3 + v.lk_dly + (v.exp_wb ? (v.wb_dly + 1) : 0);
    check({tag, " rsp seen"},   32'(got),        32'd1);
    check({tag, " latency"},    32'(lat),        32'(exp_lat));
    check({tag, " result"},     32'(res),        32'(v.exp_res));
    check({tag, " upd pulses"}, 32'(upd_cycles), 32'(v.exp_upd));
    check({tag, " err pulses"}, 32'(err_cycles), 32'(v.exp_err));
    check({tag, " lk cycles"},  32'(lk_cycles),  32'(v.lk_dly + 1));
    check({tag, " wb cycles"},  32'(wb_cycles),  32'(v.exp_wb ? (v.wb_dly + 1) : 0));
    check({tag, " addr held"},  32'(addr_ok),    32'd1);
    if (v.exp_upd) begin
      check({tag, " upd way"},  32'(uway),  32'(v.way));
      check({tag, " upd mesi"}, 32'(umesi), 32'(v.exp_mesi));
      check({tag, " upd addr"}, uaddr,      v.addr);
    end
    check({tag, " rsp drop"},   32'(rsp_valid),   32'd0);
    check({tag, " back idle"},  32'(snoop_ready), 32'd1);
    exp_snoops++;
    if (v.exp_res == 2'b10) exp_hitm++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    reset = 1'b1; snoop_valid = 1'b0; snoop_op = 2'b00; snoop_addr = 32'd0;
    lk_ack = 1'b0; lk_hit = 1'b0; lk_way = 3'd0; lk_mesi = 2'b00; wb_ack = 1'b0;

    //        op     addr           hit   way   mesi   lk wb noise  res    upd   mesi'  wb    err
    vecs[0]  = '{2'b00, 32'h0000_1A40, 1'b1, 3'd2, 2'b11, 0, 2, 1'b1, 2'b10, 1'b1, 2'b01, 1'b1, 1'b0};
    vecs[1]  = '{2'b10, 32'h0040_0000, 1'b1, 3'd5, 2'b10, 0, 0, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0};
    vecs[2]  = '{2'b11, 32'h0000_0100, 1'b0, 3'd0, 2'b00, 0, 0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0};
    vecs[3]  = '{2'b01, 32'h0000_2000, 1'b1, 3'd1, 2'b11, 0, 0, 1'b0, 2'b00, 1'b0, 2'b11, 1'b0, 1'b1};
    vecs[4]  = '{2'b00, 32'h0000_5000, 1'b1, 3'd1, 2'b10, 0, 0, 1'b0, 2'b01, 1'b1, 2'b01, 1'b0, 1'b0};
    vecs[5]  = '{2'b00, 32'h0000_6000, 1'b1, 3'd7, 2'b01, 1, 0, 1'b0, 2'b01, 1'b0, 2'b01, 1'b0, 1'b0};
    vecs[6]  = '{2'b00, 32'h0000_7000, 1'b1, 3'd3, 2'b00, 0, 0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0};
    vecs[7]  = '{2'b10, 32'h0000_8000, 1'b1, 3'd3, 2'b11, 2, 0, 1'b1, 2'b10, 1'b1, 2'b00, 1'b1, 1'b0};
    vecs[8]  = '{2'b10, 32'h0000_9000, 1'b1, 3'd4, 2'b01, 0, 0, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0};
    vecs[9]  = '{2'b11, 32'h0000_A000, 1'b1, 3'd6, 2'b01, 0, 0, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0};
    vecs[10] = '{2'b11, 32'h0000_B000, 1'b1, 3'd0, 2'b10, 0, 0, 1'b0, 2'b01, 1'b0, 2'b10, 1'b0, 1'b1};
    vecs[11] = '{2'b11, 32'hFFFF_FFC0, 1'b1, 3'd2, 2'b11, 0, 0, 1'b0, 2'b01, 1'b0, 2'b11, 1'b0, 1'b1};
    vecs[12] = '{2'b01, 32'h0000_C000, 1'b0, 3'd0, 2'b00, 0, 0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0};
    vecs[13] = '{2'b10, 32'h0000_D000, 1'b0, 3'd7, 2'b11, 0, 0, 1'b0, 2'b00, 1'b0, 2'b11, 1'b0, 1'b0};
    vecs[14] = '{2'b01, 32'h0000_E000, 1'b1, 3'd1, 2'b01, 0, 0, 1'b0, 2'b00, 1'b0, 2'b01, 1'b0, 1'b1};

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst snoop_ready", 32'(snoop_ready), 32'd1);
    check("rst strobes", 32'({lk_req, wb_req, rsp_valid, upd_valid, proto_err}), 32'd0);
    check("rst rsp_result", 32'(rsp_result), 32'd0);
    check("rst addrs", lk_addr | wb_addr | upd_addr, 32'd0);
    check("rst way/mesi", 32'({upd_way, upd_mesi}), 32'd0);
    check_stats("rst");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) run_snoop(vecs[i], $sformatf("v%0d", i));
    check_stats("table");

    // Reset while a write-back is outstanding.
    snoop_valid = 1'b1; snoop_op = 2'b00; snoop_addr = 32'h0000_03C0;
    lk_hit = 1'b1; lk_way = 3'd1; lk_mesi = 2'b11; lk_ack = 1'b0; wb_ack = 1'b0;
    cyc = 0;
    while (!wb_req && cyc < 20) begin
      @(negedge clk);
      cyc++;
      snoop_valid = 1'b0;
      lk_ack = lk_req;
    end
    lk_ack = 1'b0;
    check("midrst wb_req up", 32'(wb_req), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst wb_req drop", 32'(wb_req), 32'd0);
    check("midrst no rsp/upd", 32'({rsp_valid, upd_valid, lk_req}), 32'd0);
    reset = 1'b0;
    check("midrst ready", 32'(snoop_ready), 32'd1);
    cyc = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rsp_valid || upd_valid || wb_req) cyc++;
    end
    check("midrst quiet after", 32'(cyc), 32'd0);
    exp_snoops = 0;
    exp_hitm = 0;
    check_stats("midrst");

    // Three snoops, one of them HITM, counted from a clean reset.
    run_snoop(vecs[1], "st1");
    run_snoop(vecs[0], "st2");
    run_snoop(vecs[2], "st3");
    check_stats("stats3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_snoop_responder.md
BUS_SNOOP_RESPONDER -- requirements
Module: bus_snoop_responder

Interface
REQ-001 SHALL have parameter ADD_SIZE, default 32, bus address width.
REQ-002 SHALL have parameter WAY_BITS, default 3, way-index width.
REQ-003 SHALL have port clk, input, 1; sole clock, all state changes on rising edge.
REQ-004 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port snoop_valid, input, 1; snooped bus operation present.
REQ-006 SHALL have port snoop_op, input, 2; 00 Read, 01 Write, 10 Modify (RWIM), 11 Invalidate.
REQ-007 SHALL have port snoop_addr, input, ADD_SIZE; snooped address.
REQ-008 SHALL have port snoop_ready, output, 1; accepts snoop this cycle.
REQ-009 SHALL have ports lk_req (out, 1), lk_addr (out, ADD_SIZE), lk_ack (in, 1), lk_hit (in, 1), lk_way (in, WAY_BITS), lk_mesi (in, 2; 00 I, 01 S, 10 E, 11 M); tag-lookup handshake.
REQ-010 SHALL have ports upd_valid (out, 1), upd_addr (out, ADD_SIZE), upd_way (out, WAY_BITS), upd_mesi (out, 2); MESI update to tag store.
REQ-011 SHALL have ports wb_req (out, 1), wb_addr (out, ADD_SIZE), wb_ack (in, 1); dirty-line write-back handshake.
REQ-012 SHALL have ports rsp_valid (out, 1), rsp_result (out, 2; 00 NOHIT, 01 HIT, 10 HITM); snoop result.
REQ-013 SHALL have ports proto_err (out, 1); stat_snoops (out, 16); stat_hitm (out, 16).

Function
REQ-014 FSM states SHALL be IDLE, LOOKUP, DECIDE, WRITEBACK, RESPOND.
REQ-015 snoop_ready SHALL be 1 only in IDLE; snoop_valid&snoop_ready latches op/addr, next state LOOKUP.
REQ-016 LOOKUP: lk_req=1, lk_addr=latched addr, held until lk_ack; on lk_ack capture hit/way/mesi, go DECIDE.
REQ-017 DECIDE (one cycle): apply REQ-018..021; write-back needed -> WRITEBACK, else RESPOND.
REQ-018 Read: M -> S with write-back, HITM; E -> S, HIT; S unchanged, HIT; miss/I -> NOHIT.
REQ-019 Modify: M -> I with write-back, HITM; E or S -> I, HIT; miss/I -> NOHIT.
REQ-020 Invalidate: S -> I, HIT; E or M -> no change, HIT, proto_err; miss/I -> NOHIT.
REQ-021 Write: always NOHIT, no change; hit in non-I -> proto_err.
REQ-022 WRITEBACK: wb_req=1, wb_addr=latched addr, held until wb_ack; then RESPOND.
REQ-023 RESPOND (one cycle): rsp_valid=1 with rsp_result; upd_valid=1 same cycle only if state changes; proto_err pulses same cycle; then IDLE.
REQ-024 Minimum latency acceptance->rsp_valid SHALL be 3 cycles with lk_ack in first LOOKUP cycle and no write-back.
REQ-025 Inputs snoop_valid/snoop_op/snoop_addr SHALL be ignored outside IDLE.

Reset
REQ-026 On reset: state IDLE; snoop_ready=1 in the following cycle; lk_req, wb_req, rsp_valid, upd_valid, proto_err=0; rsp_result=00; addr/way/mesi outputs 0; stat counters 0.
REQ-027 Reset mid-operation SHALL abandon the snoop with no upd_valid, no rsp_valid, wb_req dropped next edge.

Configuration
REQ-028 With SNOOP_STATS_EN defined: stat_snoops increments per accepted snoop, stat_hitm per HITM response, both saturating at 16'hFFFF.
REQ-029 Without SNOOP_STATS_EN: stat_snoops and stat_hitm SHALL be constant 0 and no counter registers exist.

Verification
REQ-030 Read 0x0000_1A40, lookup hit way 2 mesi M -> wb_req addr 0x0000_1A40, after wb_ack rsp HITM, upd way 2 mesi S.
REQ-031 Modify 0x0040_0000, hit way 5 mesi E -> no wb_req, rsp HIT, upd way 5 mesi I, latency 3 cycles.
REQ-032 Invalidate 0x0000_0100, lookup miss -> rsp NOHIT, upd_valid 0, proto_err 0.
REQ-033 Write 0x0000_2000, hit mesi M -> rsp NOHIT, proto_err 1 for one cycle, no update, no write-back.
REQ-034 Reset asserted while wb_req=1 -> next cycle wb_req 0, no rsp_valid, snoop_ready 1 after reset release.
REQ-035 SNOOP_STATS_EN, 3 snoops incl. one HITM -> stat_snoops 3, stat_hitm 1; without macro both 0.
